// File: rtl/seven_seg_scanner_if.sv
// Connection bundle between the message-code source and the multiplexed display scanner.
interface seven_seg_if;
  logic [6:0] seg_in1;
  logic [6:0] seg_in2;
  logic [6:0] seg_in3;
  logic [6:0] seg_in4;
  logic       blink_en;
  logic [6:0] seg_out;
  logic [3:0] digit_sel;
  logic       frame_done;

  modport master (
    output seg_in1, seg_in2, seg_in3, seg_in4, blink_en,
    input  seg_out, digit_sel, frame_done
  );

  modport slave (
    input  seg_in1, seg_in2, seg_in3, seg_in4, blink_en,
    output seg_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Scans four 7-segment codes onto a shared-bus 4-digit display with per-frame
// snapshot, anti-ghosting blanking at each slot start and optional frame blink.
module seven_seg_scanner #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 32
) (
  input logic        clk,
  input logic        rst,
  seven_seg_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FCNT_HALF = FW'(BLINK_FRAMES / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [6:0]    shadow_q [4];
  logic [6:0]    shadow_d [4];
  logic          blink_l_q, blink_l_d;
  logic          snap;
  logic          active;
  logic          blink_off;

  // The snapshot point is the first cycle of slot 0, so the whole frame
  // always shows one coherent message.
  assign snap = (slot_q == 2'd0) && (cnt_q == '0);

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    slot_d    = slot_q;
    fcnt_d    = fcnt_q;
    shadow_d  = shadow_q;
    blink_l_d = blink_l_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
      if (slot_q == 2'd3) begin
        fcnt_d = (fcnt_q == FCNT_MAX) ? '0 : fcnt_q + 1'b1;
      end
    end
    if (snap) begin
      shadow_d[0] = bus.seg_in1;
      shadow_d[1] = bus.seg_in2;
      shadow_d[2] = bus.seg_in3;
      shadow_d[3] = bus.seg_in4;
      blink_l_d   = bus.blink_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      slot_q    <= 2'd0;
      fcnt_q    <= '0;
      blink_l_q <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 7'd0;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      fcnt_q    <= fcnt_d;
      blink_l_q <= blink_l_d;
      shadow_q  <= shadow_d;
    end
  end

  // Outputs decode registered state only; cnt=0 is always blank, which also
  // keeps the display dark while reset is held.
  assign active    = (cnt_q >= BLANK_END);
  assign blink_off = blink_l_q && (fcnt_q >= FCNT_HALF);

  assign bus.digit_sel  = active ? (4'b0001 << slot_q) : 4'b0000;
  assign bus.seg_out    = (active && !blink_off) ? shadow_q[slot_q] : 7'd0;
  assign bus.frame_done = (slot_q == 2'd3) && (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with PRESCALE=8, BLANK_CYCLES=2, BLINK_FRAMES=4.
module tb_seven_seg_scanner;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int BF = 4;
  localparam int FL = 4 * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  // Per-frame expected codes and visibility, filled in by each test.
  logic [6:0] fr_codes [8][4];
  bit         fr_vis   [8];

  always #5 clk = ~clk;

  seven_seg_if bus ();

  seven_seg_scanner #(
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Cycle n is the clock period ending with edge n after reset release.
  function automatic logic [3:0] exp_sel(int n);
    int c = n % P;
    int s = (n / P) % 4;
    logic [3:0] one = 4'b0001;
    return (c >= B) ? (one << s) : 4'b0000;
  endfunction

  function automatic logic [6:0] exp_seg(int n);
    int c = n % P;
    int s = (n / P) % 4;
    int f = n / FL;
    if (c < B || !fr_vis[f]) return 7'd0;
    return fr_codes[f][s];
  endfunction

  function automatic logic exp_done(int n);
    return (n % FL) == (FL - 1);
  endfunction

  task automatic set_frame(int f, logic [6:0] a, logic [6:0] b, logic [6:0] c, logic [6:0] d, bit vis);
    fr_codes[f][0] = a;
    fr_codes[f][1] = b;
    fr_codes[f][2] = c;
    fr_codes[f][3] = d;
    fr_vis[f]      = vis;
  endtask

  task automatic drive_codes(logic [6:0] a, logic [6:0] b, logic [6:0] c, logic [6:0] d);
    bus.seg_in1 = a;
    bus.seg_in2 = b;
    bus.seg_in3 = c;
    bus.seg_in4 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_codes(7'h39, 7'h5C, 7'h38, 7'h5E);
    bus.blink_en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (bus.seg_out !== 7'd0 || bus.digit_sel !== 4'd0 || bus.frame_done !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_hold: got seg=%h sel=%b done=%b required all 0",
                 bus.seg_out, bus.digit_sel, bus.frame_done);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < P; n++) begin
      cmp_cnt++;
      if (bus.digit_sel !== ((n < B) ? 4'b0000 : 4'b0001) ||
          bus.seg_out !== ((n < B) ? 7'h00 : 7'h39)) begin
        err_cnt++;
        $display("FAIL reset_first_slot cyc %0d: got sel=%b seg=%h", n, bus.digit_sel, bus.seg_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_frame();
    drive_codes(7'h39, 7'h5C, 7'h38, 7'h5E);
    bus.blink_en = 1'b0;
    set_frame(0, 7'h39, 7'h5C, 7'h38, 7'h5E, 1'b1);
    set_frame(1, 7'h39, 7'h5C, 7'h38, 7'h5E, 1'b1);
    do_reset();
    for (int n = 0; n < 2 * FL; n++) begin
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n)) begin
        err_cnt++;
        $display("FAIL cold_sel cyc %0d: got %b required %b", n, bus.digit_sel, exp_sel(n));
      end
      cmp_cnt++;
      if (bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL cold_seg cyc %0d: got %h required %h", n, bus.seg_out, exp_seg(n));
      end
      cmp_cnt++;
      if (bus.frame_done !== exp_done(n)) begin
        err_cnt++;
        $display("FAIL cold_frame_done cyc %0d: got %b required %b", n, bus.frame_done, exp_done(n));
      end
      cmp_cnt++;
      if (!$onehot0(bus.digit_sel)) begin
        err_cnt++;
        $display("FAIL cold_onehot cyc %0d: got %b required at most one bit", n, bus.digit_sel);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tearing();
    drive_codes(7'h39, 7'h5C, 7'h38, 7'h5E);
    bus.blink_en = 1'b0;
    set_frame(0, 7'h39, 7'h5C, 7'h38, 7'h5E, 1'b1);
    set_frame(1, 7'h5E, 7'h50, 7'h5C, 7'h73, 1'b1);
    do_reset();
    for (int n = 0; n < 2 * FL; n++) begin
      if (n == 10) drive_codes(7'h5E, 7'h50, 7'h5C, 7'h73);
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL tearing cyc %0d: got sel=%b seg=%h required sel=%b seg=%h",
                 n, bus.digit_sel, bus.seg_out, exp_sel(n), exp_seg(n));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blink();
    drive_codes(7'h39, 7'h5C, 7'h38, 7'h5E);
    bus.blink_en = 1'b1;
    for (int f = 0; f < 5; f++) set_frame(f, 7'h39, 7'h5C, 7'h38, 7'h5E, (f % 4) < 2);
    do_reset();
    for (int n = 0; n < 5 * FL; n++) begin
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL blink cyc %0d: got sel=%b seg=%h required sel=%b seg=%h",
                 n, bus.digit_sel, bus.seg_out, exp_sel(n), exp_seg(n));
      end
      @(negedge clk);
    end
    // Dropping blink mid-dark-frame only takes effect at the next snapshot.
    for (int f = 0; f < 4; f++) set_frame(f, 7'h39, 7'h5C, 7'h38, 7'h5E, f != 2);
    do_reset();
    for (int n = 0; n < 4 * FL; n++) begin
      if (n == 2 * FL + 16) bus.blink_en = 1'b0;
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL blink_drop cyc %0d: got sel=%b seg=%h required sel=%b seg=%h",
                 n, bus.digit_sel, bus.seg_out, exp_sel(n), exp_seg(n));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int stop_n;
    stop_n = 2 * FL + 2 * P + 5;
    drive_codes(7'h39, 7'h5C, 7'h38, 7'h5E);
    bus.blink_en = 1'b1;
    for (int f = 0; f < 3; f++) set_frame(f, 7'h39, 7'h5C, 7'h38, 7'h5E, f < 2);
    do_reset();
    for (int n = 0; n <= stop_n; n++) begin
      if (n == 2 * FL + 6) drive_codes(7'h5E, 7'h50, 7'h5C, 7'h73);
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL pre_reset cyc %0d: got sel=%b seg=%h required sel=%b seg=%h",
                 n, bus.digit_sel, bus.seg_out, exp_sel(n), exp_seg(n));
      end
      if (n == stop_n) rst = 1'b1;
      @(negedge clk);
    end
    cmp_cnt++;
    if (bus.seg_out !== 7'd0 || bus.digit_sel !== 4'd0 || bus.frame_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_out: got seg=%h sel=%b done=%b required all 0",
               bus.seg_out, bus.digit_sel, bus.frame_done);
    end
    rst = 1'b0;
    set_frame(0, 7'h5E, 7'h50, 7'h5C, 7'h73, 1'b1);
    for (int n = 0; n < FL; n++) begin
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n) ||
          bus.frame_done !== exp_done(n)) begin
        err_cnt++;
        $display("FAIL post_reset cyc %0d: got sel=%b seg=%h done=%b required sel=%b seg=%h done=%b",
                 n, bus.digit_sel, bus.seg_out, bus.frame_done, exp_sel(n), exp_seg(n), exp_done(n));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hot();
    drive_codes(7'h00, 7'h76, 7'h5C, 7'h78);
    bus.blink_en = 1'b0;
    set_frame(0, 7'h00, 7'h76, 7'h5C, 7'h78, 1'b1);
    do_reset();
    for (int n = 0; n < FL; n++) begin
      cmp_cnt++;
      if (bus.digit_sel !== exp_sel(n) || bus.seg_out !== exp_seg(n)) begin
        err_cnt++;
        $display("FAIL hot cyc %0d: got sel=%b seg=%h required sel=%b seg=%h",
                 n, bus.digit_sel, bus.seg_out, exp_sel(n), exp_seg(n));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    drive_codes(7'h00, 7'h00, 7'h00, 7'h00);
    bus.blink_en = 1'b0;
    for (int f = 0; f < 8; f++) set_frame(f, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_tearing();
    test_blink();
    test_reset_mid();
    test_hot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumes the four 7-segment codes produced by the baggage-drop display logic (the COLD / HOT / DROP messages).
- Drives them onto a single physical 4-digit multiplexed display: one shared segment bus plus one-hot digit enables.
- Snapshots the four codes once per frame so a message change mid-scan never shows a mix of two messages.
- Inserts anti-ghosting blanking at the start of each digit slot and supports an optional frame-based blink.

Parameters:
- PRESCALE, 1000: clock cycles per digit slot. Legal range: BLANK_CYCLES < PRESCALE.
- BLANK_CYCLES, 16: blanked cycles at the start of each slot. Legal range: at least 1.
- BLINK_FRAMES, 32: blink period in frames. Must be even and at least 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- seg_in1  input  7  code for digit 1 (leftmost), bit order {g,f,e,d,c,b,a}, 1 = segment lit
- seg_in2  input  7  code for digit 2
- seg_in3  input  7  code for digit 3
- seg_in4  input  7  code for digit 4 (rightmost)
- blink_en  input  1  1 = blink the whole display
- seg_out  output  7  shared segment bus, same encoding as seg_in*
- digit_sel  output  4  one-hot digit enable, active-high; bit0 = digit 1, bit3 = digit 4
- frame_done  output  1  single-cycle pulse on the last cycle of each frame

Behaviour:
- One clock domain, rst synchronous active-high. Every register updates on the rising edge of clk.
- State registers:
  - cnt: 0..PRESCALE-1, cycle within slot
  - slot: 0..3
  - fcnt: 0..BLINK_FRAMES-1, frame counter
  - shadow1..4: 7 bits each
  - blink_l: latched blink_en
- Reset (rst=1 on an edge): cnt=0, slot=0, fcnt=0, shadow*=0, blink_l=0. rst overrides all other activity, including reset asserted mid-slot or mid-frame.
- Outputs are a combinational decode of registered state only; no input feeds an output combinationally.
- Output values while rst is held: seg_out=0, digit_sel=0, frame_done=0. This follows from cnt=0, which always falls in the blank window.
- Counting: each non-reset edge increments cnt.
  - At cnt=PRESCALE-1: cnt wraps to 0 and slot increments.
  - At slot=3: slot wraps to 0 and fcnt increments modulo BLINK_FRAMES.
- Frame length: 4*PRESCALE cycles.
- Snapshot: on any non-reset edge where slot=0 and cnt=0, load shadowN <= seg_inN and blink_l <= blink_en.
  - This also occurs on the first edge after reset release.
  - Inputs are ignored at all other times; changes appear from the next frame.
- Blank window (cnt < BLANK_CYCLES): digit_sel=0, seg_out=0.
- Active window (cnt >= BLANK_CYCLES):
  - digit_sel = 1 << slot.
  - seg_out = shadow[slot+1], unless blink is suppressing.
  - Blink suppresses when blink_l=1 and fcnt >= BLINK_FRAMES/2. seg_out is then forced to 0 while digit_sel still follows the slot.
- digit_sel is never multi-hot. It changes only on a blank-window boundary, and a zero-hot period of at least BLANK_CYCLES separates any two different digits.
- frame_done = 1 exactly when slot=3 and cnt=PRESCALE-1.
- fcnt counts regardless of blink_en. With blink_l=0, output is identical to the blink-free case.
- A code of 0x00 (space) is displayed as all segments off. It is not treated specially.

Test Plan:
Bench parameters: PRESCALE=8, BLANK_CYCLES=2, BLINK_FRAMES=4. Cycle numbers count edges after rst deasserts; cycle 0 is the snapshot edge.
- Reset:
  - Stimulus: hold rst for 3 cycles with seg_in = 0x39,0x5C,0x38,0x5E.
  - Response: all outputs 0 during reset. After release, cycles 0-1 blank. Cycles 2-7: digit_sel=0001, seg_out=0x39.
- Full frame, "COLD":
  - Response: slots show 0x39/0001, 0x5C/0010, 0x38/0100, 0x5E/1000, each active 6 cycles after 2 blank cycles.
  - frame_done is high only at cycles 31, 63, ....
  - digit_sel is never multi-hot.
- Tearing:
  - Stimulus: switch inputs to "DROP" (0x5E,0x50,0x5C,0x73) at cycle 10.
  - Response: frame 0 still shows 0x5C, 0x38, 0x5E. Frame 1 (from cycle 32) shows 0x5E, 0x50, 0x5C, 0x73.
- Blink:
  - Stimulus: blink_en=1 from before cycle 0.
  - Response: frames 0-1 show codes; frames 2-3 show seg_out=0 with digit_sel still cycling; pattern repeats from frame 4.
  - Stimulus: drop blink_en mid-frame 2.
  - Response: frame 2 stays dark; frame 3 shows codes.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle at slot 2, cnt 5.
  - Response: next cycle outputs 0. Scan restarts at slot 0 with a fresh snapshot and fcnt=0, so blink phase restarts visible.
- "HOT" message:
  - Stimulus: seg_in = 0x00,0x76,0x5C,0x78.
  - Response: slot 0 active window has digit_sel=0001, seg_out=0x00. Remaining slots show 0x76, 0x5C, 0x78.
